// File: rtl/dp_ctrl_pkg.sv
// dp_ctrl_pkg -- shared definitions for the decimal-point controller.
//   MODE_*      : encodings of the 2-bit i_mode input
//   state_t     : controller state enum (CLK, SET, ALM, SW)
//   modeToState : decodes i_mode into the state it selects
//   posWidth    : width of the field-select input (at least 1 bit)
package dp_ctrl_pkg;

  localparam logic [1:0] MODE_CLK = 2'b00;
  localparam logic [1:0] MODE_SET = 2'b01;
  localparam logic [1:0] MODE_ALM = 2'b10;
  localparam logic [1:0] MODE_SW  = 2'b11;

  typedef enum logic [1:0] {
    ST_CLK = 2'b00,
    ST_SET = 2'b01,
    ST_ALM = 2'b10,
    ST_SW  = 2'b11
  } state_t;

  function automatic state_t modeToState(input logic [1:0] mode);
    case (mode)
      MODE_SET: return ST_SET;
      MODE_ALM: return ST_ALM;
      MODE_SW:  return ST_SW;
      default:  return ST_CLK;
    endcase
  endfunction

  // A single field still needs a 1-bit select port.
  function automatic int posWidth(input int fields);
    return (fields > 1) ? $clog2(fields) : 1;
  endfunction

endpackage

// File: rtl/dp_ctrl_if.sv
// dp_ctrl_if -- mode/position inputs and decimal-point outputs of dp_ctrl.
//   i_mode     : 00 clock, 01 time-set, 10 alarm-set, 11 stopwatch
//   i_position : selected field, 0 = least-significant field
//   o_dp       : decimal-point enables, bit 0 = rightmost digit
//   o_phase    : blink phase, 1 = lit half-period
// master modport drives the inputs; slave modport is the controller side.
interface dp_ctrl_if #(
  parameter int DIGITS  = 6,
  parameter int FIELD_W = 2
);
  import dp_ctrl_pkg::*;

  localparam int FIELDS = DIGITS / FIELD_W;
  localparam int POS_W  = posWidth(FIELDS);

  logic [1:0]        i_mode;
  logic [POS_W-1:0]  i_position;
  logic [DIGITS-1:0] o_dp;
  logic              o_phase;

  modport master (output i_mode, output i_position, input o_dp, input o_phase);
  modport slave  (input i_mode, input i_position, output o_dp, output o_phase);

endinterface

// File: rtl/dp_prescaler.sv
// dp_prescaler -- free-running 0..DIV-1 counter producing the blink tick.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   clear : synchronous restart of the count at 0
//   tick  : high for the one cycle in which the count is DIV-1
module dp_prescaler #(
  parameter int DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_count;

  assign tick = (r_count == CW'(DIV - 1));

  // clear wins over the natural wrap so a restart always begins a full period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear || tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/dp_ctrl.sv
// dp_ctrl -- decimal-point controller for a seven-segment clock display.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : dp_ctrl_if.slave (i_mode, i_position in; o_dp, o_phase out)
// Build option: define DP_BLINK_EN to make CLK/SET decimal points blink;
// without it the phase is held lit.
module dp_ctrl
  import dp_ctrl_pkg::*;
#(
  parameter int DIGITS    = 6,
  parameter int FIELD_W   = 2,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  dp_ctrl_if.slave   bus
);

  localparam int FIELDS = DIGITS / FIELD_W;
  localparam int POS_W  = posWidth(FIELDS);
  localparam int CHW    = $clog2(DIGITS);

  // Field separators: first digit of every field except the rightmost one.
  function automatic logic [DIGITS-1:0] clkMask();
    logic [DIGITS-1:0] m;
    m = '0;
    for (int f = 1; f < FIELDS; f++) m[f*FIELD_W] = 1'b1;
    return m;
  endfunction

  localparam logic [DIGITS-1:0] CLK_MASK = clkMask();

  state_t            r_state, w_stateNext;
  logic [POS_W-1:0]  r_pos;
  logic              r_phase, w_phaseNext;
  logic [CHW-1:0]    r_chase, w_chaseNext;
  logic [DIGITS-1:0] r_dp, w_dpNext;
  logic              w_tick, w_restart, w_posValid;
  logic [31:0]       w_posIdx;

  dp_prescaler #(.DIV(BLINK_DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (w_restart),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_CLK;
    else        r_state <= w_stateNext;
  end

  // Output is computed from next-cycle values so o_dp and o_phase stay aligned
  // and a mode/position change shows up on the very next edge.
  always_comb begin
    w_stateNext = modeToState(bus.i_mode);
    w_restart   = (w_stateNext != r_state) || (bus.i_position != r_pos);
    w_posIdx    = 32'(bus.i_position);
    w_posValid  = (w_posIdx < 32'(FIELDS));

`ifdef DP_BLINK_EN
    w_phaseNext = r_phase;
    if (w_restart)   w_phaseNext = 1'b1;
    else if (w_tick) w_phaseNext = ~r_phase;
`else
    w_phaseNext = 1'b1;
`endif

    w_chaseNext = r_chase;
    if (w_restart)   w_chaseNext = '0;
    else if (w_tick) w_chaseNext = (r_chase == CHW'(DIGITS - 1)) ? '0 : r_chase + CHW'(1);

    w_dpNext = '0;
    case (w_stateNext)
      ST_CLK: if (w_phaseNext)               w_dpNext = CLK_MASK;
      ST_SET: if (w_phaseNext && w_posValid) w_dpNext = DIGITS'(1) << (w_posIdx * FIELD_W);
      ST_ALM: if (w_posValid)                w_dpNext = DIGITS'(1) << (w_posIdx * FIELD_W);
      ST_SW:                                 w_dpNext = DIGITS'(1) << w_chaseNext;
      default:                               w_dpNext = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos   <= '0;
      r_phase <= 1'b1;
      r_chase <= '0;
      r_dp    <= '0;
    end else begin
      r_pos   <= bus.i_position;
      r_phase <= w_phaseNext;
      r_chase <= w_chaseNext;
      r_dp    <= w_dpNext;
    end
  end

  assign bus.o_dp    = r_dp;
  assign bus.o_phase = r_phase;

endmodule

// File: tb/tb_dp_ctrl.sv
// tb_dp_ctrl -- directed self-checking bench for dp_ctrl
// (DIGITS=6, FIELD_W=2, BLINK_DIV=4). Expectations follow DP_BLINK_EN.
module tb_dp_ctrl;
  import dp_ctrl_pkg::*;

`ifdef DP_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   testsRun = 0;
  int   failCount = 0;

  dp_ctrl_if #(.DIGITS(6), .FIELD_W(2)) bus ();

  dp_ctrl #(.DIGITS(6), .FIELD_W(2), .BLINK_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Off-phase value: dark when blinking, unchanged when blink is disabled.
  function automatic logic [5:0] offDp(input logic [5:0] lit);
    return BLINK ? 6'b000000 : lit;
  endfunction

  task automatic applyStimulus(input logic [1:0] mode, input logic [1:0] pos);
    bus.i_mode     = mode;
    bus.i_position = pos;
  endtask

  task automatic stepEdges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [5:0] expDp, input logic expPhase);
    testsRun++;
    assert (bus.o_dp === expDp)
      else begin
        failCount++;
        $error("[TB] FAIL %s o_dp: observed %b expected %b", tag, bus.o_dp, expDp);
      end
    testsRun++;
    assert (bus.o_phase === expPhase)
      else begin
        failCount++;
        $error("[TB] FAIL %s o_phase: observed %b expected %b", tag, bus.o_phase, expPhase);
      end
  endtask

  initial begin
    logic [5:0] expSw;
    applyStimulus(MODE_CLK, 2'd0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset", 6'b000000, 1'b1);

    // Clock mode: lit through edge 3, toggles on edges 4 and 8.
    rst_n = 1'b1;
    stepEdges(1); checkOutput("clk_e1", 6'b010100, 1'b1);
    stepEdges(2); checkOutput("clk_e3", 6'b010100, 1'b1);
    stepEdges(1); checkOutput("clk_e4", offDp(6'b010100), !BLINK);
    stepEdges(3); checkOutput("clk_e7", offDp(6'b010100), !BLINK);
    stepEdges(1); checkOutput("clk_e8", 6'b010100, 1'b1);

    // Time-set, field 2, then move to field 0 during the dark half.
    applyStimulus(MODE_SET, 2'd2);
    stepEdges(1); checkOutput("set_p2_e0", 6'b010000, 1'b1);
    stepEdges(3); checkOutput("set_p2_e3", 6'b010000, 1'b1);
    stepEdges(1); checkOutput("set_p2_e4", offDp(6'b010000), !BLINK);
    stepEdges(2); checkOutput("set_p2_e6", offDp(6'b010000), !BLINK);
    applyStimulus(MODE_SET, 2'd0);
    stepEdges(1); checkOutput("set_p0_e0", 6'b000001, 1'b1);
    stepEdges(3); checkOutput("set_p0_e3", 6'b000001, 1'b1);
    stepEdges(1); checkOutput("set_p0_e4", offDp(6'b000001), !BLINK);

    // Alarm-set is steady regardless of phase; out-of-range field is dark.
    applyStimulus(MODE_ALM, 2'd1);
    for (int i = 0; i < 20; i++) begin
      stepEdges(1);
      testsRun++;
      assert (bus.o_dp === 6'b000100)
        else begin
          failCount++;
          $error("[TB] FAIL alm_p1[%0d] o_dp: observed %b expected %b", i, bus.o_dp, 6'b000100);
        end
    end
    applyStimulus(MODE_ALM, 2'd3);
    stepEdges(1); checkOutput("alm_p3", 6'b000000, 1'b1);

    // Stopwatch chase: one step per 4 edges, wrapping after bit 5.
    applyStimulus(MODE_SW, 2'd3);
    stepEdges(1); checkOutput("sw_k0", 6'b000001, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      expSw = 6'b000001 << ((k - 1) % 6);
      stepEdges(3); checkOutput($sformatf("sw_hold%0d", k), expSw, (k % 2 == 1) ? 1'b1 : !BLINK);
      expSw = 6'b000001 << (k % 6);
      stepEdges(1); checkOutput($sformatf("sw_step%0d", k), expSw, (k % 2 == 0) ? 1'b1 : !BLINK);
    end

    // Leaving and re-entering stopwatch restarts the chase.
    applyStimulus(MODE_CLK, 2'd3);
    stepEdges(1); checkOutput("sw_exit", 6'b010100, 1'b1);
    applyStimulus(MODE_SW, 2'd3);
    stepEdges(1); checkOutput("sw_reentry", 6'b000001, 1'b1);
    stepEdges(3); checkOutput("sw_re_e3", 6'b000001, 1'b1);
    stepEdges(1); checkOutput("sw_re_e4", 6'b000010, !BLINK);

    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    #1 checkOutput("async_rst", 6'b000000, 1'b1);
    applyStimulus(MODE_CLK, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stepEdges(1); checkOutput("post_rst", 6'b010100, 1'b1);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/dp_ctrl.md
DP_CTRL -- requirements
Module: dp_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 6: number of seven-segment digits driven (even, 2..16).
REQ-002 SHALL have parameter FIELD_W, default 2: digits per editable field; FIELDS = DIGITS/FIELD_W.
REQ-003 SHALL have parameter BLINK_DIV, default 25_000_000: clk cycles per blink half-period (>=2).
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_mode  input  2  00 clock, 01 time-set, 10 alarm-set, 11 stopwatch.
REQ-007 SHALL have port i_position  input  clog2(FIELDS)  selected field, 0 = least-significant field.
REQ-008 SHALL have port o_dp  output  DIGITS  decimal-point enables, bit 0 = rightmost digit, registered.
REQ-009 SHALL have port o_phase  output  1  current blink phase, 1 = lit half-period, registered.

Function
REQ-010 SHALL keep a prescaler counting 0..BLINK_DIV-1 that wraps and raises an internal tick for one cycle at BLINK_DIV-1.
REQ-011 SHALL toggle the blink phase on every tick.
REQ-012 SHALL have states CLK, SET, ALM, SW, entered from i_mode with one cycle of latency.
REQ-013 CLK: o_dp bits f*FIELD_W for f=1..FIELDS-1 SHALL be set when phase=1, all bits 0 when phase=0 (DIGITS=6: 010100 / 000000).
REQ-014 SET: o_dp bit i_position*FIELD_W SHALL be set when phase=1, all bits 0 when phase=0.
REQ-015 ALM: o_dp bit i_position*FIELD_W SHALL be set steadily, independent of phase.
REQ-016 SW: exactly one o_dp bit SHALL be set at chase index k, with k advancing by 1 per tick and wrapping DIGITS-1 -> 0.
REQ-017 SET/ALM with i_position >= FIELDS SHALL drive o_dp all zero, with no other state effect.
REQ-018 Any change of state or of i_position SHALL clear the prescaler, force phase to 1 and chase index to 0 on the next edge.
REQ-019 If a state or position change coincides with a tick, the restart of REQ-018 SHALL take priority (phase=1, index 0).
REQ-020 o_dp SHALL reflect inputs and state with exactly one cycle of register latency.

Reset
REQ-021 During rst_n=0: o_dp=0, o_phase=1, prescaler=0, chase index=0, state=CLK.
REQ-022 Reset assertion mid-operation SHALL clear all outputs immediately, without waiting for clk.
REQ-023 First edge after rst_n deassertion SHALL evaluate i_mode normally.

Configuration
REQ-024 Macro DP_BLINK_EN defined: blink behaviour as in REQ-011..REQ-014.
REQ-025 Macro DP_BLINK_EN undefined: phase held at 1, so CLK and SET are steady; prescaler and SW chase still operate.

Structure
REQ-026 Package dp_ctrl_pkg SHALL hold the mode encodings (MODE_CLK=00, MODE_SET=01, MODE_ALM=10, MODE_SW=11) and the state enum typedef.
REQ-027 Prescaler and tick SHALL sit in sub-module dp_prescaler (parameter DIV, inputs clk, rst_n, clear; output tick).

Verification (DIGITS=6, FIELD_W=2, BLINK_DIV=4)
REQ-028 Reset, then i_mode=00 -> o_dp=010100 for 4 cycles, then 000000 for 4 cycles, repeating; o_phase mirrors this.
REQ-029 i_mode=01, i_position=2 -> o_dp alternates 010000/000000 every 4 cycles; switching to position 0 mid-off-phase -> 000001 on the next edge.
REQ-030 i_mode=10, i_position=1 -> o_dp=000100 constant over 20 cycles; i_position=3 -> 000000.
REQ-031 i_mode=11 -> o_dp walks 000001, 000010 ... 100000, 000001, one step per 4 cycles; a mode change to 00 and back restarts at 000001.
REQ-032 rst_n pulsed low between edges in SW mode -> o_dp=000000 asynchronously; after release, state CLK, o_dp=010100.
REQ-033 Build without DP_BLINK_EN, i_mode=01, i_position=0 -> o_dp=000001 constant; SW chase unchanged.
